// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, condition-flag bit positions,
// and the interrupt-context state type used by the flag unit.
package cpu_pkg;

  // Flag-setting ALU opcodes
  localparam logic [4:0] ADD = 5'b00001;
  localparam logic [4:0] SUB = 5'b00010;
  localparam logic [4:0] CMP = 5'b00011;

  // Branch opcodes consuming the flags
  localparam logic [4:0] BEQ = 5'b01000;
  localparam logic [4:0] BLT = 5'b01001;
  localparam logic [4:0] BGT = 5'b01010;
  localparam logic [4:0] BNE = 5'b01011;

  // Bit positions inside the 2-bit flags word
  localparam int unsigned FLAG_EQ = 1;
  localparam int unsigned FLAG_LT = 0;

  typedef enum logic {
    NORMAL = 1'b0,
    IN_ISR = 1'b1
  } isr_state_t;

  function automatic logic is_flag_op(input logic [4:0] op);
    return (op == ADD) || (op == SUB) || (op == CMP);
  endfunction

endpackage

// File: rtl/flag_calc.sv
// flag_calc: combinational EQ/LT flag generation from an ALU result.
//   alu_result - ALU result (WIDTH bits)
//   alu_ovf    - signed-overflow indication for alu_result
//   flags_n    - {EQ, LT}: EQ = result is zero, LT = overflow-corrected sign
module flag_calc
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_ovf,
  output logic [1:0]       flags_n
);

  always_comb begin
    flags_n          = '0;
    flags_n[FLAG_EQ] = (alu_result == '0);
    // Overflow flips the apparent sign, so XOR recovers the true signed LT
    flags_n[FLAG_LT] = alu_result[WIDTH-1] ^ alu_ovf;
  end

endmodule

// File: rtl/flag_unit.sv
// flag_unit: architectural condition-flags register at the end of EX, with
// one-level save/restore across interrupt entry/return.
//   clk, rst              - clock, asynchronous active-high reset
//   ex_valid/ex_opcode    - instruction in EX
//   alu_result/alu_ovf    - ALU result and signed overflow for that instruction
//   stall/flush           - pipeline hold / squash of the EX instruction
//   irq_enter/irq_return  - interrupt entry / return pulses
//   flags_out             - registered flags {EQ, LT} to the branch stage
//   flags_upd             - one-cycle pulse after every flags register write
//   in_isr                - high while inside an interrupt handler
//   nest_err              - one-cycle pulse after an illegal irq_enter/irq_return
module flag_unit
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [4:0]       ex_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_ovf,
  input  logic             stall,
  input  logic             flush,
  input  logic             irq_enter,
  input  logic             irq_return,
  output logic [1:0]       flags_out,
  output logic             flags_upd,
  output logic             in_isr,
  output logic             nest_err
);

  isr_state_t state, state_n;

  logic [1:0] flags_q, shadow_q;
  logic [1:0] flags_d, shadow_d;
  logic [1:0] calc_flags;
  logic       commit, enter_ok, return_ok, nest_bad;
  logic       upd_q, nest_q;

  flag_calc #(.WIDTH(WIDTH)) u_calc (
    .alu_result (alu_result),
    .alu_ovf    (alu_ovf),
    .flags_n    (calc_flags)
  );

  // Event decode: simultaneous enter+return cancels both
  always_comb begin
    commit    = ex_valid & ~stall & ~flush & is_flag_op(ex_opcode);
    enter_ok  = irq_enter & ~irq_return & (state == NORMAL);
    return_ok = irq_return & ~irq_enter & (state == IN_ISR);
    nest_bad  = (irq_enter | irq_return) & ~(enter_ok | return_ok);
  end

  // Flags datapath: restore beats commit; shadow captures post-edge flags
  always_comb begin
    flags_d  = flags_q;
    shadow_d = shadow_q;
    if (return_ok)
      flags_d = shadow_q;
    else if (commit)
      flags_d = calc_flags;
    if (enter_ok)
      shadow_d = flags_d;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= NORMAL;
    else
      state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      NORMAL: if (enter_ok)  state_n = IN_ISR;
      IN_ISR: if (return_ok) state_n = NORMAL;
      default: state_n = NORMAL;
    endcase
  end

  // Datapath and pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q  <= '0;
      shadow_q <= '0;
      upd_q    <= 1'b0;
      nest_q   <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      shadow_q <= shadow_d;
      upd_q    <= return_ok | commit;
      nest_q   <= nest_bad;
    end
  end

  // Outputs: all driven straight from registers
  always_comb begin
    flags_out = flags_q;
    flags_upd = upd_q;
    nest_err  = nest_q;
    in_isr    = (state == IN_ISR);
  end

endmodule

// File: tb/tb_flag_unit.sv
module tb_flag_unit;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ex_valid = 1'b0;
  logic [4:0]       ex_opcode = '0;
  logic [WIDTH-1:0] alu_result = '0;
  logic             alu_ovf = 1'b0;
  logic             stall = 1'b0;
  logic             flush = 1'b0;
  logic             irq_enter = 1'b0;
  logic             irq_return = 1'b0;
  logic [1:0]       flags_out;
  logic             flags_upd;
  logic             in_isr;
  logic             nest_err;

  flag_unit #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_opcode  (ex_opcode),
    .alu_result (alu_result),
    .alu_ovf    (alu_ovf),
    .stall      (stall),
    .flush      (flush),
    .irq_enter  (irq_enter),
    .irq_return (irq_return),
    .flags_out  (flags_out),
    .flags_upd  (flags_upd),
    .in_isr     (in_isr),
    .nest_err   (nest_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] flags;
    logic       upd;
    logic       isr;
    logic       nerr;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;
  event chk_ev;
  bit   hold_rst = 1'b1;

  // Reference model state
  logic [1:0] m_flags  = 2'b00;
  logic [1:0] m_shadow = 2'b00;
  bit         m_isr    = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Predicts the outputs visible after the next rising edge from the
  // currently driven inputs, using the architectural rules directly.
  task automatic model_step();
    exp_t e;
    bit   commit, legal_enter, legal_return;
    logic [1:0] computed;
    e = '0;
    if (rst) begin
      m_flags = 2'b00; m_shadow = 2'b00; m_isr = 1'b0;
    end else begin
      commit = ex_valid && !stall && !flush && (ex_opcode >= 5'd1) && (ex_opcode <= 5'd3);
      computed[1] = (alu_result == 0);
      computed[0] = (($signed(alu_result) < 0) != alu_ovf);
      legal_enter  = irq_enter && !irq_return && !m_isr;
      legal_return = irq_return && !irq_enter && m_isr;
      e.nerr = (irq_enter || irq_return) && !(legal_enter || legal_return);
      if (legal_return) begin
        m_flags = m_shadow; m_isr = 1'b0; e.upd = 1'b1;
      end else if (commit) begin
        m_flags = computed; e.upd = 1'b1;
      end
      if (legal_enter) begin
        m_shadow = m_flags; m_isr = 1'b1;
      end
    end
    e.flags = m_flags;
    e.isr   = m_isr;
    q.push_back(e);
  endtask

  task automatic cyc(input logic v, input logic [4:0] op, input logic [31:0] res,
                     input logic ovf, input logic st, input logic fl,
                     input logic ent, input logic ret);
    @(negedge clk);
    rst = hold_rst;
    ex_valid = v; ex_opcode = op; alu_result = res; alu_ovf = ovf;
    stall = st; flush = fl; irq_enter = ent; irq_return = ret;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 5'd0, 32'd0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare outputs against the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("flags_out", int'(flags_out), int'(e.flags));
        check("flags_upd", int'(flags_upd), int'(e.upd));
        check("in_isr",    int'(in_isr),    int'(e.isr));
        check("nest_err",  int'(nest_err),  int'(e.nerr));
      end
    end
  end

  initial begin
    // Reset held for two cycles, then released
    idle(2);
    hold_rst = 1'b0;
    idle(1);

    // SUB with zero result -> EQ set, pulse then drop
    cyc(1, 5'b00010, 32'd0, 0, 0, 0, 0, 0);
    idle(1);
    // CMP at the most negative value: overflow clears LT, no overflow sets it
    cyc(1, 5'b00011, 32'h8000_0000, 1, 0, 0, 0, 0);
    cyc(1, 5'b00011, 32'h8000_0000, 0, 0, 0, 0, 0);
    // Gated commits: non-flag opcode, flush, stall
    cyc(1, 5'b00100, 32'd0, 0, 0, 0, 0, 0);
    cyc(1, 5'b00001, 32'd0, 0, 0, 1, 0, 0);
    cyc(1, 5'b00001, 32'd0, 0, 1, 0, 0, 0);
    idle(1);

    // Interrupt round trip with nested-enter error in the middle
    cyc(1, 5'b00010, 32'd0, 0, 0, 0, 0, 0);          // flags = 10
    cyc(0, 5'd0, 32'd0, 0, 0, 0, 1, 0);              // enter
    cyc(1, 5'b00001, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);  // flags = 01
    cyc(0, 5'd0, 32'd0, 0, 0, 0, 1, 0);              // nested enter -> error
    idle(1);
    cyc(1, 5'b00010, 32'd5, 0, 0, 0, 0, 1);          // return beats commit
    idle(1);
    cyc(0, 5'd0, 32'd0, 0, 0, 0, 0, 1);              // return in NORMAL
    cyc(0, 5'd0, 32'd0, 0, 0, 0, 1, 1);              // simultaneous -> error
    // Entry with same-cycle commit saves the new flags; stalled return honoured
    cyc(1, 5'b00001, 32'd7, 1, 0, 0, 1, 0);
    cyc(1, 5'b00001, 32'd0, 0, 0, 0, 0, 0);
    cyc(1, 5'b00001, 32'd9, 0, 1, 0, 0, 1);
    idle(1);

    // Asynchronous reset inside an ISR with flags = 11
    cyc(0, 5'd0, 32'd0, 0, 0, 0, 1, 0);
    cyc(1, 5'b00001, 32'd0, 1, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    m_flags = 2'b00; m_shadow = 2'b00; m_isr = 1'b0;
    q.push_back('0);
    ->chk_ev;
    hold_rst = 1'b1;
    cyc(1, 5'b00001, 32'd0, 1, 0, 0, 0, 1);          // lost under reset
    hold_rst = 1'b0;
    cyc(0, 5'd0, 32'd0, 0, 0, 0, 0, 1);              // return after reset -> error
    idle(1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [4:0]  op;
      logic [31:0] res;
      case ($urandom_range(0, 3))
        0: op = 5'b00001;
        1: op = 5'b00010;
        2: op = 5'b00011;
        default: op = 5'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0: res = 32'd0;
        1: res = 32'h8000_0000;
        2: res = 32'hFFFF_FFFF;
        3: res = 32'h7FFF_FFFF;
        default: res = $urandom;
      endcase
      cyc($urandom_range(0, 3) != 0, op, res, 1'($urandom),
          $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
    end
    idle(2);

    @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Absolute time limit so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout at %0t: got running expected finished", $time);
    $fatal(1);
  end

endmodule
